// File: rtl/fetch_pkg.sv
// Shared definitions for the miniRISC fetch front end: redirect-type
// encodings driven by execute and the fetch sequencer state encoding.
package fetch_pkg;

    // Redirect kinds carried on redir_type
    localparam logic [1:0] REDIR_SHORT = 2'b00;  // pc + 1 + signed offset
    localparam logic [1:0] REDIR_LONG  = 2'b01;  // {pc upper bits, jump field}
    localparam logic [1:0] REDIR_REG   = 2'b10;  // absolute register target
    localparam logic [1:0] REDIR_NONE  = 2'b11;  // reserved, ignored

    // Fetch sequencer: RUN issues and buffers, FLUSH drains stale responses
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with occupancy count and a single-cycle flush.
// Push into a full FIFO is accepted when a pop happens in the same cycle.
// The head word reads as zero while the FIFO is empty.
module fetch_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Qualify requests against occupancy; pop frees the slot a full push needs
    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != FULL_COUNT) || do_pop);
    end

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; flush empties the FIFO in one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Head word, forced to zero when nothing is buffered
    always_comb begin
        dout = (count != '0) ? mem[rd_ptr] : '0;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: issues word-addressed requests under a
// credit limit, pairs in-order responses with their PCs, buffers them in a
// prefetch FIFO for decode, and handles redirects from execute by flushing
// the buffer and dropping responses that were already in flight.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned INSTR_WIDTH  = 32,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned JTARGET_BITS = 26,
    parameter int unsigned OFFSET_BITS  = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    imem_req_valid,
    input  logic                    imem_req_ready,
    output logic [ADDR_WIDTH-1:0]   imem_req_addr,
    input  logic                    imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0]  imem_rsp_data,
    output logic                    inst_valid,
    input  logic                    inst_ready,
    output logic [INSTR_WIDTH-1:0]  inst_data,
    output logic [ADDR_WIDTH-1:0]   inst_pc,
    input  logic                    redir_valid,
    input  logic [1:0]              redir_type,
    input  logic [ADDR_WIDTH-1:0]   redir_pc,
    input  logic [OFFSET_BITS-1:0]  redir_offset,
    input  logic [JTARGET_BITS-1:0] redir_jtarget,
    input  logic [ADDR_WIDTH-1:0]   redir_reg,
    output logic                    busy
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned EW = INSTR_WIDTH + ADDR_WIDTH;
    localparam logic [CW:0] CREDIT_LIMIT = (CW + 1)'(FIFO_DEPTH);

    fetch_state_t          state;
    fetch_state_t          state_nxt;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] fetch_pc_nxt;
    logic [ADDR_WIDTH-1:0] target;
    logic [CW-1:0]         discard;
    logic [CW-1:0]         discard_nxt;
    logic [CW-1:0]         buf_count;
    logic [CW-1:0]         outstanding;
    logic [CW:0]           in_use;
    logic                  run_en;
    logic                  redir_go;
    logic                  req_fire;
    logic                  pop_fire;
    logic                  buf_push;
    logic [ADDR_WIDTH-1:0] pend_pc;
    logic [EW-1:0]         buf_din;
    logic [EW-1:0]         buf_dout;

    // Redirect target selection, all arithmetic modulo 2^ADDR_WIDTH
    always_comb begin
        redir_go = redir_valid && (redir_type != REDIR_NONE);
        case (redir_type)
            REDIR_SHORT: target = redir_pc + ADDR_WIDTH'(1)
                                  + {{(ADDR_WIDTH-OFFSET_BITS){redir_offset[OFFSET_BITS-1]}},
                                     redir_offset};
            REDIR_LONG:  target = {redir_pc[ADDR_WIDTH-1:JTARGET_BITS], redir_jtarget};
            REDIR_REG:   target = redir_reg;
            default:     target = fetch_pc;
        endcase
    end

    // Credit check: buffered plus in-flight never exceeds FIFO capacity, so
    // every response has a slot waiting for it
    always_comb begin
        in_use         = {1'b0, buf_count} + {1'b0, outstanding};
        imem_req_valid = run_en && (state == ST_RUN) && (in_use < CREDIT_LIMIT)
                         && !redir_valid;
        imem_req_addr  = fetch_pc;
        req_fire       = imem_req_valid && imem_req_ready;
        pop_fire       = inst_valid && inst_ready;
        buf_push       = (state == ST_RUN) && imem_rsp_valid && !redir_go;
        buf_din        = {imem_rsp_data, pend_pc};
        busy           = (state == ST_FLUSH);
    end

    // Next-state, next-PC and discard count for the RUN/FLUSH sequencer
    always_comb begin
        state_nxt    = state;
        discard_nxt  = discard;
        fetch_pc_nxt = fetch_pc;
        if (req_fire) begin
            fetch_pc_nxt = fetch_pc + ADDR_WIDTH'(1);
        end
        if (redir_go) begin
            fetch_pc_nxt = target;
        end
        case (state)
            ST_RUN: begin
                if (redir_go) begin
                    // a response landing this cycle is already accounted for
                    discard_nxt = outstanding - CW'(imem_rsp_valid);
                    state_nxt   = (discard_nxt != '0) ? ST_FLUSH : ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (imem_rsp_valid) begin
                    discard_nxt = discard - CW'(1);
                    if (discard_nxt == '0) begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // Sequencer registers; run_en holds the request port low until the
    // first edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_RUN;
            discard  <= '0;
            fetch_pc <= RESET_PC;
            run_en   <= 1'b0;
        end else begin
            state    <= state_nxt;
            discard  <= discard_nxt;
            fetch_pc <= fetch_pc_nxt;
            run_en   <= 1'b1;
        end
    end

    // PCs of issued requests, consumed in order by every response; its
    // occupancy is the outstanding-request count
    fetch_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_pend_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .push  (req_fire),
        .din   (fetch_pc),
        .pop   (imem_rsp_valid),
        .dout  (pend_pc),
        .count (outstanding)
    );

    // Prefetch buffer of {instruction, pc} presented to decode
    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redir_go),
        .push  (buf_push),
        .din   (buf_din),
        .pop   (pop_fire),
        .dout  (buf_dout),
        .count (buf_count)
    );

    assign inst_valid = (buf_count != '0);
    assign inst_data  = buf_dout[EW-1:ADDR_WIDTH];
    assign inst_pc    = buf_dout[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-configurable memory model
// answers requests in order; every accepted request pushes the expected
// {pc, instruction} and every decode handshake pops and compares.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redir_valid;
    logic [1:0]  redir_type;
    logic [31:0] redir_pc;
    logic [15:0] redir_offset;
    logic [25:0] redir_jtarget;
    logic [31:0] redir_reg;
    logic        busy;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redir_valid    (redir_valid),
        .redir_type     (redir_type),
        .redir_pc       (redir_pc),
        .redir_offset   (redir_offset),
        .redir_jtarget  (redir_jtarget),
        .redir_reg      (redir_reg),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    mreq_t       mq[$];
    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          lat      = 1;
    logic [31:0] exp_fetch;
    bit          exp_busy;
    int          exp_discard;
    bit          last_acc;
    bit          last_pop;
    bit          last_rsp;
    logic [31:0] last_addr;
    logic [31:0] last_pc;
    int          n_acc;
    int          n_pop;
    int          n_busy;
    int          n_drop;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] ref_target(input logic [1:0] t, input logic [31:0] pc,
                                               input logic [15:0] off, input logic [25:0] jt,
                                               input logic [31:0] r);
        case (t)
            2'b00:   return pc + 32'd1 + {{16{off[15]}}, off};
            2'b01:   return {pc[31:26], jt};
            default: return r;
        endcase
    endfunction

    // One clock cycle, entered and left at the falling edge
    task automatic tick();
        exp_t e;
        bit   go;
        if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memword(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        last_acc = imem_req_valid && imem_req_ready;
        last_pop = inst_valid && inst_ready;
        last_rsp = imem_rsp_valid;
        go       = redir_valid && (redir_type != 2'b11);
        check("busy", busy, exp_busy);
        if (busy) begin
            n_busy++;
            check("req_in_flush", imem_req_valid, 0);
            if (last_rsp) n_drop++;
        end
        if (last_pop) begin
            n_pop++;
            last_pc = inst_pc;
            check("sb_has_entry", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("inst_pc", inst_pc, e.pc);
                check("inst_data", inst_data, e.data);
            end
        end
        if (last_acc) begin
            n_acc++;
            last_addr = imem_req_addr;
            check("req_addr", imem_req_addr, exp_fetch);
            sb.push_back(exp_t'{exp_fetch, memword(exp_fetch)});
            mq.push_back(mreq_t'{imem_req_addr, cyc + 1 + lat});
            exp_fetch++;
        end
        if (last_rsp) void'(mq.pop_front());
        if (exp_busy) begin
            if (last_rsp) begin
                exp_discard--;
                if (exp_discard == 0) exp_busy = 1'b0;
            end
            if (go) exp_fetch = ref_target(redir_type, redir_pc, redir_offset, redir_jtarget, redir_reg);
        end else if (go) begin
            sb.delete();
            exp_fetch   = ref_target(redir_type, redir_pc, redir_offset, redir_jtarget, redir_reg);
            exp_discard = mq.size();
            exp_busy    = (exp_discard > 0);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redir_valid    = 1'b0;
        mq.delete();
        sb.delete();
        exp_fetch   = 32'h0;
        exp_busy    = 1'b0;
        exp_discard = 0;
        n_acc  = 0;
        n_pop  = 0;
        n_busy = 0;
        n_drop = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_accept(input string tag, output logic [31:0] a);
        int k = 0;
        do begin
            tick();
            k++;
        end while (!last_acc && k < 60);
        check({tag, "_timeout"}, last_acc, 1);
        a = last_addr;
    endtask

    task automatic wait_pop(input string tag, output logic [31:0] p);
        int k = 0;
        do begin
            tick();
            k++;
        end while (!last_pop && k < 60);
        check({tag, "_timeout"}, last_pop, 1);
        p = last_pc;
    endtask

    task automatic redirect(input logic [1:0] t, input logic [31:0] pc, input logic [15:0] off,
                            input logic [25:0] jt, input logic [31:0] r);
        redir_valid   = 1'b1;
        redir_type    = t;
        redir_pc      = pc;
        redir_offset  = off;
        redir_jtarget = jt;
        redir_reg     = r;
        tick();
        redir_valid   = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_req_valid"}, imem_req_valid, 0);
        check({tag, "_inst_valid"}, inst_valid, 0);
        check({tag, "_inst_data"}, inst_data, 0);
        check({tag, "_inst_pc"}, inst_pc, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] saved;
        int          p;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        redir_valid    = 1'b0;
        redir_type     = 2'b00;
        redir_pc       = '0;
        redir_offset   = '0;
        redir_jtarget  = '0;
        redir_reg      = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        #2;
        check_zero_outputs("reset");

        // Latency 1, decode always ready: in-order stream from PC 0
        do_reset();
        lat = 1;
        wait_pop("t1_first", a);
        check("t1_first_pc", a, 32'h0);
        repeat (30) tick();
        check("t1_stream", n_pop >= 25, 1);

        // Decode stalled: credit limits issue to four requests
        do_reset();
        inst_ready = 1'b0;
        repeat (10) tick();
        check("t2_acc_count", n_acc, 4);
        check("t2_req_valid", imem_req_valid, 0);
        check("t2_inst_valid", inst_valid, 1);
        check("t2_head_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        wait_accept("t2_resume", a);
        check("t2_resume_addr", a, 32'h4);
        repeat (8) tick();

        // Latency 3: short branch with two requests in flight
        do_reset();
        lat = 3;
        imem_req_ready = 1'b0;
        repeat (2) tick();
        imem_req_ready = 1'b1;
        repeat (2) tick();
        imem_req_ready = 1'b0;
        check("t3_in_flight", mq.size(), 2);
        redirect(2'b00, 32'h10, 16'hFFFE, '0, '0);
        imem_req_ready = 1'b1;
        wait_accept("t3_accept", a);
        check("t3_target", a, 32'h0F);
        check("t3_busy_cycles", n_busy, 2);
        check("t3_dropped", n_drop, 2);
        wait_pop("t3_pop", a);
        check("t3_first_pc", a, 32'h0F);

        // Long jump, register branch, reserved type, wrap-around
        lat = 1;
        repeat (6) tick();
        redirect(2'b01, 32'hFC00_0005, '0, 26'h000_0123, '0);
        wait_accept("t4_accept", a);
        check("t4_long_target", a, 32'hFC00_0123);
        repeat (6) tick();
        redirect(2'b10, '0, '0, '0, 32'h40);
        wait_accept("t5_accept", a);
        check("t5_reg_target", a, 32'h40);
        repeat (6) tick();
        saved = exp_fetch;
        redirect(2'b11, 32'h1234, 16'h0005, 26'h3FF_FFFF, 32'h999);
        wait_accept("t6_accept", a);
        check("t6_reserved_ignored", a, saved);
        repeat (4) tick();
        redirect(2'b10, '0, '0, '0, 32'hFFFF_FFFF);
        wait_accept("t7_top", a);
        check("t7_top_addr", a, 32'hFFFF_FFFF);
        wait_accept("t7_wrap", a);
        check("t7_wrap_addr", a, 32'h0);
        repeat (6) tick();

        // Redirect coinciding with a response and a decode pop
        check("t8_pre_valid", inst_valid, 1);
        check("t8_pre_rsp", (mq.size() > 0) && (mq[0].due <= cyc + 1), 1);
        p = n_pop;
        redirect(2'b10, '0, '0, '0, 32'h200);
        check("t8_popped", n_pop - p, 1);
        check("t8_fifo_empty", inst_valid, 0);
        check("t8_busy", busy, 0);
        wait_accept("t8_accept", a);
        check("t8_target", a, 32'h200);
        repeat (6) tick();

        // Reset asserted in FLUSH with three requests outstanding
        do_reset();
        lat = 4;
        imem_req_ready = 1'b0;
        repeat (2) tick();
        imem_req_ready = 1'b1;
        repeat (3) tick();
        imem_req_ready = 1'b0;
        check("t9_in_flight", mq.size(), 3);
        redirect(2'b10, '0, '0, '0, 32'h80);
        check("t9_flushing", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        check_zero_outputs("t9_async");
        imem_req_ready = 1'b1;
        @(negedge clk);
        do_reset();
        lat = 1;
        wait_accept("t9_restart", a);
        check("t9_restart_addr", a, 32'h0);
        check("t9_busy_after", busy, 0);
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
